// File: rtl/ddr3_axi_ctrl.sv
// ddr3_axi_ctrl: AXI4 slave front end issuing one store/fetch burst at a time to a DDR3 controller port.
// Illegal bursts never reach memory; they are drained or synthesised locally with SLVERR.
module ddr3_axi_ctrl #(
    parameter int WIDTH = 32,
    parameter int MASKS = WIDTH / 8,
    parameter int ADDRS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             axi_awvalid_i,
    output logic             axi_awready_o,
    input  logic [ADDRS-1:0] axi_awaddr_i,
    input  logic [3:0]       axi_awid_i,
    input  logic [7:0]       axi_awlen_i,
    input  logic [1:0]       axi_awburst_i,
    input  logic             axi_wvalid_i,
    output logic             axi_wready_o,
    input  logic             axi_wlast_i,
    input  logic [MASKS-1:0] axi_wstrb_i,
    input  logic [WIDTH-1:0] axi_wdata_i,
    output logic             axi_bvalid_o,
    input  logic             axi_bready_i,
    output logic [1:0]       axi_bresp_o,
    output logic [3:0]       axi_bid_o,
    input  logic             axi_arvalid_i,
    output logic             axi_arready_o,
    input  logic [ADDRS-1:0] axi_araddr_i,
    input  logic [3:0]       axi_arid_i,
    input  logic [7:0]       axi_arlen_i,
    input  logic [1:0]       axi_arburst_i,
    output logic             axi_rvalid_o,
    input  logic             axi_rready_i,
    output logic             axi_rlast_o,
    output logic [1:0]       axi_rresp_o,
    output logic [3:0]       axi_rid_o,
    output logic [WIDTH-1:0] axi_rdata_o,
    output logic             mem_store_o,
    output logic             mem_fetch_o,
    input  logic             mem_accept_i,
    input  logic             mem_error_i,
    output logic [3:0]       mem_req_id_o,
    output logic [ADDRS-1:0] mem_addr_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic             mem_last_o,
    output logic [MASKS-1:0] mem_wrmask_o,
    output logic [WIDTH-1:0] mem_wrdata_o,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic             mem_last_i,
    input  logic [3:0]       mem_resp_id_i,
    input  logic [WIDTH-1:0] mem_rddata_i
);
    localparam logic [2:0] IDLE = 3'd0, WCMD = 3'd1, WDATA = 3'd2, WRESP = 3'd3, RCMD = 3'd4, RDATA = 3'd5;
    logic [2:0]       state_q, state_d;
    logic             rdy_q, ill_q, err_q;
    logic [ADDRS-1:0] addr_q;
    logic [3:0]       id_q;
    logic [7:0]       len_q, beat_q;
    logic             aw_hs, ar_hs, aw_legal, ar_legal, wr, rd;
    assign aw_hs    = rdy_q & axi_awvalid_i;
    assign ar_hs    = axi_arready_o & axi_arvalid_i;
    assign aw_legal = axi_awburst_i == 2'b01 && axi_awlen_i == 8'd3;
    assign ar_legal = axi_arburst_i == 2'b01 && axi_arlen_i == 8'd3;
    assign wr       = state_q == WDATA;
    assign rd       = state_q == RDATA;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = aw_hs ? (aw_legal ? WCMD : WDATA) : ar_hs ? (ar_legal ? RCMD : RDATA) : IDLE;
            WCMD:    state_d = mem_accept_i ? WDATA : WCMD;
            WDATA:   state_d = axi_wvalid_i && axi_wready_o && axi_wlast_i ? WRESP : WDATA;
            WRESP:   state_d = axi_bready_i ? IDLE : WRESP;
            RCMD:    state_d = mem_accept_i ? RDATA : RCMD;
            RDATA:   state_d = axi_rvalid_o && axi_rready_i && axi_rlast_o ? IDLE : RDATA;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= state_d == IDLE;
            if (aw_hs) begin
                addr_q <= axi_awaddr_i;
                id_q   <= axi_awid_i;
                len_q  <= axi_awlen_i;
                ill_q  <= !aw_legal;
                err_q  <= !aw_legal;
                beat_q <= '0;
            end else if (ar_hs) begin
                addr_q <= axi_araddr_i;
                id_q   <= axi_arid_i;
                len_q  <= axi_arlen_i;
                ill_q  <= !ar_legal;
                err_q  <= 1'b0;
                beat_q <= '0;
            end else begin
                // error is only sampled before WRESP so the B payload stays stable while waiting
                if ((state_q == WCMD || wr) && mem_error_i) err_q <= 1'b1;
                if (axi_rvalid_o && axi_rready_i) beat_q <= beat_q + 8'd1;
            end
        end
    end
    assign axi_awready_o = rdy_q;
    assign axi_arready_o = rdy_q & ~axi_awvalid_i;
    assign mem_store_o   = state_q == WCMD;
    assign mem_fetch_o   = state_q == RCMD;
    assign mem_addr_o    = addr_q & ~ADDRS'(MASKS - 1);
    assign mem_req_id_o  = id_q;
    assign axi_wready_o  = wr & (ill_q | mem_ready_i);
    assign mem_valid_o   = wr & ~ill_q & axi_wvalid_i;
    assign mem_last_o    = wr & ~ill_q & axi_wlast_i;
    assign mem_wrdata_o  = axi_wdata_i;
    assign mem_wrmask_o  = axi_wstrb_i;
    assign axi_bvalid_o  = state_q == WRESP;
    assign axi_bid_o     = id_q;
    assign axi_bresp_o   = axi_bvalid_o && err_q ? 2'b10 : 2'b00;
    assign axi_rvalid_o  = rd & (ill_q | mem_valid_i);
    assign mem_ready_o   = rd & ~ill_q & axi_rready_i;
    assign axi_rdata_o   = ill_q ? '0 : mem_rddata_i;
    assign axi_rlast_o   = rd & (ill_q ? beat_q == len_q : mem_last_i);
    assign axi_rid_o     = ill_q ? id_q : mem_resp_id_i;
    assign axi_rresp_o   = rd && (ill_q || mem_error_i) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_ddr3_axi_ctrl.sv
// tb_ddr3_axi_ctrl: directed bench for ddr3_axi_ctrl; inputs change on the falling edge,
// outputs are checked shortly after, and the bench plays the memory side by hand.
module tb_ddr3_axi_ctrl;
    logic        clock = 1'b0, reset = 1'b1;
    logic        axi_awvalid_i = 0, axi_awready_o;
    logic [31:0] axi_awaddr_i = 0;
    logic [3:0]  axi_awid_i = 0;
    logic [7:0]  axi_awlen_i = 0;
    logic [1:0]  axi_awburst_i = 0;
    logic        axi_wvalid_i = 0, axi_wready_o, axi_wlast_i = 0;
    logic [3:0]  axi_wstrb_i = 0;
    logic [31:0] axi_wdata_i = 0;
    logic        axi_bvalid_o, axi_bready_i = 0;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i = 0, axi_arready_o;
    logic [31:0] axi_araddr_i = 0;
    logic [3:0]  axi_arid_i = 0;
    logic [7:0]  axi_arlen_i = 0;
    logic [1:0]  axi_arburst_i = 0;
    logic        axi_rvalid_o, axi_rready_i = 0, axi_rlast_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic        mem_store_o, mem_fetch_o, mem_accept_i = 0, mem_error_i = 0;
    logic [3:0]  mem_req_id_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_o, mem_ready_i = 0, mem_last_o;
    logic [3:0]  mem_wrmask_o;
    logic [31:0] mem_wrdata_o;
    logic        mem_valid_i = 0, mem_ready_o, mem_last_i = 0;
    logic [3:0]  mem_resp_id_i = 0;
    logic [31:0] mem_rddata_i = 0;
    int n_cmp = 0, n_err = 0, n_store = 0, n_fetch = 0, n_scyc = 0, n_clash = 0, s0;
    logic [31:0] d [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    ddr3_axi_ctrl dut (
        .clock(clock), .reset(reset),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wlast_i(axi_wlast_i),
        .axi_wstrb_i(axi_wstrb_i), .axi_wdata_i(axi_wdata_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
        .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rlast_o(axi_rlast_o),
        .axi_rresp_o(axi_rresp_o), .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o),
        .mem_store_o(mem_store_o), .mem_fetch_o(mem_fetch_o), .mem_accept_i(mem_accept_i),
        .mem_error_i(mem_error_i), .mem_req_id_o(mem_req_id_o), .mem_addr_o(mem_addr_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_last_o(mem_last_o),
        .mem_wrmask_o(mem_wrmask_o), .mem_wrdata_o(mem_wrdata_o),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_last_i(mem_last_i),
        .mem_resp_id_i(mem_resp_id_i), .mem_rddata_i(mem_rddata_i)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_store_o && mem_accept_i) n_store <= n_store + 1;
        if (mem_fetch_o && mem_accept_i) n_fetch <= n_fetch + 1;
        if (mem_store_o) n_scyc <= n_scyc + 1;
        if (mem_store_o && mem_fetch_o) n_clash <= n_clash + 1;
    end

    task automatic step;
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] bu);
        axi_awvalid_i = 1; axi_awaddr_i = a; axi_awid_i = id; axi_awlen_i = len; axi_awburst_i = bu;
        #1 chk("awready", axi_awready_o, 1);
        step;
        axi_awvalid_i = 0;
    endtask

    task automatic ar_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] bu);
        axi_arvalid_i = 1; axi_araddr_i = a; axi_arid_i = id; axi_arlen_i = len; axi_arburst_i = bu;
        #1 chk("arready", axi_arready_o, 1);
        step;
        axi_arvalid_i = 0;
    endtask

    task automatic accept_cmd;
        mem_accept_i = 1;
        step;
        mem_accept_i = 0;
    endtask

    task automatic w_beat(input logic [31:0] wd, input logic [3:0] st, input logic last, input logic legal);
        axi_wvalid_i = 1; axi_wdata_i = wd; axi_wstrb_i = st; axi_wlast_i = last; mem_ready_i = 1;
        #1 chk("wready", axi_wready_o, 1);
        chk("mem_valid", mem_valid_o, legal);
        if (legal) begin
            chk("mem_wrdata", mem_wrdata_o, wd);
            chk("mem_wrmask", mem_wrmask_o, st);
            chk("mem_last", mem_last_o, last);
        end
        step;
        axi_wvalid_i = 0; axi_wlast_i = 0;
    endtask

    task automatic b_take(input logic [3:0] id, input logic [1:0] resp);
        #1 chk("bvalid", axi_bvalid_o, 1);
        chk("bid", axi_bid_o, id);
        chk("bresp", axi_bresp_o, resp);
        axi_bready_i = 1;
        step;
        axi_bready_i = 0;
        #1 chk("bvalid_drop", axi_bvalid_o, 0);
    endtask

    task automatic r_beat(input logic [31:0] rd, input logic last, input logic [3:0] id);
        mem_valid_i = 1; mem_rddata_i = rd; mem_last_i = last; mem_resp_id_i = id; axi_rready_i = 1;
        #1 chk("rvalid", axi_rvalid_o, 1);
        chk("rdata", axi_rdata_o, rd);
        chk("rlast", axi_rlast_o, last);
        chk("rid", axi_rid_o, id);
        chk("rresp", axi_rresp_o, 0);
        chk("mem_ready", mem_ready_o, 1);
        step;
        mem_valid_i = 0; mem_last_i = 0; axi_rready_i = 0;
    endtask

    initial begin
        repeat (3) step;
        chk("rst_awready", axi_awready_o, 0);
        chk("rst_arready", axi_arready_o, 0);
        chk("rst_store", mem_store_o, 0);
        chk("rst_fetch", mem_fetch_o, 0);
        chk("rst_bvalid", axi_bvalid_o, 0);
        chk("rst_rvalid", axi_rvalid_o, 0);
        chk("rst_wready", axi_wready_o, 0);
        chk("rst_memvalid", mem_valid_o, 0);
        chk("rst_resp", {axi_bresp_o, axi_rresp_o}, 0);
        reset = 0;
        step;
        chk("idle_arready", axi_arready_o, 1);
        // T1 legal write
        aw_go(32'h0, 4'd5, 8'd3, 2'b01);
        #1 chk("t1_store", mem_store_o, 1);
        chk("t1_addr", mem_addr_o, 0);
        chk("t1_id", mem_req_id_o, 5);
        chk("t1_awready_busy", axi_awready_o, 0);
        accept_cmd;
        #1 chk("t1_store_drop", mem_store_o, 0);
        for (int i = 0; i < 4; i++) w_beat(d[i], 4'hF, i == 3, 1);
        b_take(4'd5, 2'b00);
        chk("t1_nstore", n_store, 1);
        // T2 read back
        ar_go(32'h0, 4'd9, 8'd3, 2'b01);
        #1 chk("t2_fetch", mem_fetch_o, 1);
        chk("t2_addr", mem_addr_o, 0);
        chk("t2_id", mem_req_id_o, 9);
        accept_cmd;
        for (int i = 0; i < 4; i++) r_beat(d[i], i == 3, 4'd9);
        #1 chk("t2_rvalid_idle", axi_rvalid_o, 0);
        chk("t2_nfetch", n_fetch, 1);
        // T3 unaligned address, slow accept, stalled beat, memory error
        aw_go(32'h13, 4'd3, 8'd3, 2'b01);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_store_hold", mem_store_o, 1);
            chk("t3_addr", mem_addr_o, 32'h10);
            chk("t3_id", mem_req_id_o, 3);
            step;
        end
        accept_cmd;
        w_beat(32'hAAAA0001, 4'h3, 0, 1);
        axi_wvalid_i = 1; mem_ready_i = 0; mem_error_i = 1;
        #1 chk("t3_wready_stall", axi_wready_o, 0);
        chk("t3_memvalid_stall", mem_valid_o, 1);
        step;
        mem_error_i = 0;
        w_beat(32'hAAAA0002, 4'hC, 0, 1);
        w_beat(32'hAAAA0003, 4'h1, 0, 1);
        w_beat(32'hAAAA0004, 4'h8, 1, 1);
        b_take(4'd3, 2'b10);
        chk("t3_nstore", n_store, 2);
        // T4/T5 simultaneous AW/AR, write wins; B and R back-pressure
        axi_awvalid_i = 1; axi_awaddr_i = 32'h40; axi_awid_i = 4'd1; axi_awlen_i = 8'd3; axi_awburst_i = 2'b01;
        axi_arvalid_i = 1; axi_araddr_i = 32'h80; axi_arid_i = 4'd2; axi_arlen_i = 8'd3; axi_arburst_i = 2'b01;
        #1 chk("t4_awready", axi_awready_o, 1);
        chk("t4_arready_blocked", axi_arready_o, 0);
        step;
        axi_awvalid_i = 0;
        #1 chk("t4_store", mem_store_o, 1);
        chk("t4_no_fetch", mem_fetch_o, 0);
        accept_cmd;
        for (int i = 0; i < 4; i++) w_beat(d[3-i], 4'hF, i == 3, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_bvalid_hold", axi_bvalid_o, 1);
            chk("t5_bid_hold", axi_bid_o, 1);
            chk("t5_bresp_hold", axi_bresp_o, 0);
            chk("t4_arready_busy", axi_arready_o, 0);
            step;
        end
        b_take(4'd1, 2'b00);
        chk("t4_fetch_after_b", n_fetch, 1);
        chk("t4_arready_idle", axi_arready_o, 1);
        step;
        axi_arvalid_i = 0;
        #1 chk("t4_fetch", mem_fetch_o, 1);
        chk("t4_faddr", mem_addr_o, 32'h80);
        chk("t4_fid", mem_req_id_o, 2);
        accept_cmd;
        mem_valid_i = 1; mem_rddata_i = 32'hDEAD; mem_resp_id_i = 4'd2; axi_rready_i = 0;
        #1 chk("t5_memready_low", mem_ready_o, 0);
        chk("t5_rvalid_stall", axi_rvalid_o, 1);
        step;
        for (int i = 0; i < 4; i++) r_beat(d[i] ^ 32'hFF, i == 3, 4'd2);
        chk("t4_nfetch", n_fetch, 2);
        // T6 illegal write bursts
        s0 = n_scyc;
        aw_go(32'h100, 4'd6, 8'd3, 2'b00);
        #1 chk("t6_no_store", mem_store_o, 0);
        chk("t6_wready_drain", axi_wready_o, 1);
        w_beat(32'h1, 4'hF, 0, 0);
        w_beat(32'h2, 4'hF, 1, 0);
        b_take(4'd6, 2'b10);
        aw_go(32'h100, 4'd7, 8'd7, 2'b01);
        w_beat(32'h3, 4'hF, 1, 0);
        b_take(4'd7, 2'b10);
        chk("t6_store_cycles", n_scyc, s0);
        // illegal read burst synthesised locally
        ar_go(32'h200, 4'hC, 8'd1, 2'b10);
        #1 chk("t6_no_fetch", mem_fetch_o, 0);
        axi_rready_i = 1;
        #1 chk("t6_rvalid0", axi_rvalid_o, 1);
        chk("t6_rdata0", axi_rdata_o, 0);
        chk("t6_rresp0", axi_rresp_o, 2'b10);
        chk("t6_rid0", axi_rid_o, 4'hC);
        chk("t6_rlast0", axi_rlast_o, 0);
        step;
        #1 chk("t6_rvalid1", axi_rvalid_o, 1);
        chk("t6_rlast1", axi_rlast_o, 1);
        step;
        axi_rready_i = 0;
        #1 chk("t6_rvalid_done", axi_rvalid_o, 0);
        chk("t6_nfetch", n_fetch, 2);
        // reset during WDATA
        aw_go(32'h0, 4'd4, 8'd3, 2'b01);
        accept_cmd;
        axi_wvalid_i = 1; mem_ready_i = 1;
        #1 chk("t6_wdata_live", mem_valid_o, 1);
        reset = 1;
        step;
        #1 chk("t6_rst_memvalid", mem_valid_o, 0);
        chk("t6_rst_wready", axi_wready_o, 0);
        chk("t6_rst_awready", axi_awready_o, 0);
        chk("t6_rst_store", mem_store_o, 0);
        reset = 0; axi_wvalid_i = 0;
        step;
        #1 chk("t6_post_awready", axi_awready_o, 1);
        chk("t6_post_bvalid", axi_bvalid_o, 0);
        chk("no_clash", n_clash, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
